// File: rtl/switch_debounce_pkg.sv
// Shared constants and helpers for the slide-switch debouncer.
// Optional feature macro: SWITCH_DEBOUNCE_EDGE_EN (adds rise/fall/changed outputs).
package switch_debounce_pkg;

    localparam int SW_WIDTH_DEF     = 18;
    localparam int TICK_DIV_DEF     = 50000;
    localparam int STABLE_TICKS_DEF = 8;

    // Stability counter width; holds STABLE_TICKS-1 for every legal STABLE_TICKS (1..15).
    localparam int CNT_W = 4;

    // Ceiling log2, used to size the prescaler so it can reach TICK_DIV-1.
    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        for (int i = 0; i < 32; i++) begin
            if (((value - 32'sd1) >> i) != 32'sd0) begin
                result = i + 32'sd1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One debounced switch bit: 2-flop synchroniser, stability counter, output flop
// and, when SWITCH_DEBOUNCE_EDGE_EN is defined, registered rise/fall pulses.
module switch_debounce_bit
    import switch_debounce_pkg::*;
#(
    parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic in_bit,
    output logic out_bit
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    ,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic accept
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             sync0_r;
    logic             sync1_r;
    logic [CNT_W-1:0] cnt_r;
    logic             out_r;
    logic             mismatch_s;
    logic             accept_s;

    // A new level is accepted on the tick that completes the stability interval.
    assign mismatch_s = sync1_r ^ out_r;
    assign accept_s   = mismatch_s & tick & (cnt_r == CNT_LAST);
    assign out_bit    = out_r;

    // Two-flop synchroniser bringing the raw switch level into clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync0_r <= 1'b0;
            sync1_r <= 1'b0;
        end else begin
            sync0_r <= in_bit;
            sync1_r <= sync0_r;
        end
    end

    // Count ticks while the synchronised level disagrees with the output; any agreement restarts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else if (!mismatch_s) begin
            cnt_r <= '0;
        end else if (tick) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Debounced output level, updated only when the interval completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_r <= 1'b0;
        end else if (accept_s) begin
            out_r <= sync1_r;
        end else begin
            out_r <= out_r;
        end
    end

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    logic rise_r;
    logic fall_r;

    assign rise_pulse = rise_r;
    assign fall_pulse = fall_r;
    assign accept     = accept_s;

    // One-cycle edge pulses, coincident with the output flop update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            rise_r <= accept_s & sync1_r;
            fall_r <= accept_s & ~sync1_r;
        end
    end
`endif

endmodule

// File: rtl/switch_debounce.sv
// Slide-switch conditioner: shared sample-tick prescaler plus WIDTH independent
// debounced bits. Optional feature macro: SWITCH_DEBOUNCE_EDGE_EN adds
// rise_pulse, fall_pulse and changed outputs.
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int WIDTH        = SW_WIDTH_DEF,
    parameter int TICK_DIV     = TICK_DIV_DEF,
    parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    ,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             changed
`endif
);

    // A one-state prescaler (TICK_DIV=1) still needs a 1-bit register.
    localparam int              PRE_W    = (TICK_DIV > 1) ? clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_cnt_r;
    logic             tick_s;

    // Tick marks the last count of each prescaler period.
    assign tick_s = (pre_cnt_r == PRE_LAST);

    // Free-running prescaler counting 0..TICK_DIV-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt_r <= '0;
        end else if (tick_s) begin
            pre_cnt_r <= '0;
        end else begin
            pre_cnt_r <= pre_cnt_r + PRE_W'(1);
        end
    end

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] accept_s;
    logic             changed_r;

    assign changed = changed_r;

    // Summary change flag, registered so it lines up with the per-bit pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            changed_r <= 1'b0;
        end else begin
            changed_r <= |accept_s;
        end
    end
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        switch_debounce_bit #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_bit (
            .clk        (clk),
            .reset_n    (reset_n),
            .tick       (tick_s),
            .in_bit     (in_port[i]),
            .out_bit    (out_port[i])
`ifdef SWITCH_DEBOUNCE_EDGE_EN
            ,
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i]),
            .accept     (accept_s[i])
`endif
        );
    end

endmodule

// File: tb/tb_switch_debounce.sv
// Self-checking bench for switch_debounce (WIDTH=18, TICK_DIV=4, STABLE_TICKS=3).
// The reference model counts sample ticks seen since the synchronised input
// last agreed with the debounced output, using plain integer arithmetic.
module tb_switch_debounce;

    localparam int W  = 18;
    localparam int TD = 4;
    localparam int ST = 3;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] in_port = '0;
    logic [W-1:0] out_port;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;
    logic         changed;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [W-1:0] d1, d2;
    logic [W-1:0] exp_out, exp_rise, exp_fall;
    logic         exp_changed;
    int           edge_k;
    int           ticks_seen [W];

    switch_debounce #(
        .WIDTH        (W),
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_port    (in_port),
        .out_port   (out_port)
`ifdef SWITCH_DEBOUNCE_EDGE_EN
        ,
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .changed    (changed)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        d1 = '0; d2 = '0; exp_out = '0; exp_rise = '0; exp_fall = '0;
        exp_changed = 1'b0; edge_k = 0;
        for (int i = 0; i < W; i++) ticks_seen[i] = 0;
    endtask

    // Model of one clock edge: input seen two edges late, tick every TD-th edge after reset.
    task automatic model_edge(input logic [W-1:0] inp);
        logic [W-1:0] sync_v, nxt;
        bit tick_v;
        sync_v = d2;
        tick_v = ((edge_k % TD) == TD - 1);
        nxt = exp_out; exp_rise = '0; exp_fall = '0;
        for (int i = 0; i < W; i++) begin
            if (sync_v[i] == exp_out[i]) ticks_seen[i] = 0;
            else if (tick_v) begin
                ticks_seen[i]++;
                if (ticks_seen[i] == ST) begin
                    nxt[i] = sync_v[i];
                    ticks_seen[i] = 0;
                    if (sync_v[i]) exp_rise[i] = 1'b1; else exp_fall[i] = 1'b1;
                end
            end
        end
        exp_changed = |(exp_rise | exp_fall);
        exp_out = nxt; d2 = d1; d1 = inp; edge_k++;
    endtask

    // Advance one clock, update the model at the edge, return on the falling edge.
    task automatic step();
        @(posedge clk);
        if (!reset_n) model_reset(); else model_edge(in_port);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic test_reset();
        int n; bit seen;
        reset_n = 1'b0; in_port = 18'h3FFFF;
        model_reset();
        repeat (3) begin
            step();
            vectors++;
            if (out_port !== 18'h00000) begin
                miscompares++; $display("FAIL reset_out: got %h want %h", out_port, 18'h00000);
            end
`ifdef SWITCH_DEBOUNCE_EDGE_EN
            vectors++;
            if ({rise_pulse, fall_pulse, changed} !== '0) begin
                miscompares++; $display("FAIL reset_pulses: rise %h fall %h chg %b want 0", rise_pulse, fall_pulse, changed);
            end
`endif
        end
        reset_n = 1'b1;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            step(); n++;
            vectors++;
            if (out_port !== exp_out) begin
                miscompares++; $display("FAIL release_track: got %h want %h", out_port, exp_out);
            end
            if (out_port === 18'h3FFFF) seen = 1'b1;
        end
        vectors++;
        if (!seen || n < 11 || n > 14) begin
            miscompares++; $display("FAIL release_latency: got %0d clk (seen=%0d) want 11..14", n, seen);
        end
    endtask

    task automatic test_clean_change();
        int n; bit seen;
        in_port = '0; idle(20);
        vectors++;
        if (out_port !== 18'h00000) begin
            miscompares++; $display("FAIL clean_settle: got %h want %h", out_port, 18'h00000);
        end
        in_port[0] = 1'b1;
        n = 0; seen = 1'b0;
        while (!seen && n < 30) begin
            step(); n++;
            vectors++;
            if (out_port !== exp_out) begin
                miscompares++; $display("FAIL clean_track: got %h want %h", out_port, exp_out);
            end
            if (out_port[0] === 1'b1) seen = 1'b1;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
            vectors++;
            if (rise_pulse[0] !== out_port[0] || changed !== out_port[0]) begin
                miscompares++; $display("FAIL clean_pulse: rise0 %b chg %b want %b", rise_pulse[0], changed, out_port[0]);
            end
`endif
        end
        vectors++;
        if (!seen || n < 11 || n > 14) begin
            miscompares++; $display("FAIL clean_latency: got %0d clk (seen=%0d) want 11..14", n, seen);
        end
        step();
`ifdef SWITCH_DEBOUNCE_EDGE_EN
        vectors++;
        if (rise_pulse !== '0 || changed !== 1'b0) begin
            miscompares++; $display("FAIL clean_pulse_width: rise %h chg %b want 0", rise_pulse, changed);
        end
`endif
        vectors++;
        if (out_port !== 18'h00001) begin
            miscompares++; $display("FAIL clean_hold: got %h want %h", out_port, 18'h00001);
        end
    endtask

    task automatic test_bounce();
        int n, pulses; bit seen;
        in_port = '0; idle(20);
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            in_port[5] = (k != 1);
            repeat ((k < 2) ? 5 : 0) begin
                step();
                vectors++;
                if (out_port !== exp_out || out_port[5] !== 1'b0) begin
                    miscompares++; $display("FAIL bounce_early: got %h want %h", out_port, exp_out);
                end
`ifdef SWITCH_DEBOUNCE_EDGE_EN
                if (rise_pulse[5] || fall_pulse[5]) pulses++;
`endif
            end
        end
        n = 0; seen = 1'b0;
        while (!seen && n < 30) begin
            step(); n++;
            vectors++;
            if (out_port !== exp_out) begin
                miscompares++; $display("FAIL bounce_track: got %h want %h", out_port, exp_out);
            end
            if (out_port[5] === 1'b1) seen = 1'b1;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
            if (rise_pulse[5] || fall_pulse[5]) pulses++;
`endif
        end
        vectors++;
        if (!seen || n < 11 || n > 14) begin
            miscompares++; $display("FAIL bounce_latency: got %0d clk (seen=%0d) want 11..14", n, seen);
        end
`ifdef SWITCH_DEBOUNCE_EDGE_EN
        vectors++;
        if (pulses != 1) begin
            miscompares++; $display("FAIL bounce_pulses: got %0d want 1", pulses);
        end
`endif
    endtask

    task automatic test_glitch();
        in_port = '0; idle(20);
        in_port[17] = 1'b1; step(); in_port[17] = 1'b0;
        repeat (20) begin
            step();
            vectors++;
            if (out_port !== exp_out || out_port[17] !== 1'b0) begin
                miscompares++; $display("FAIL glitch_out: got %h want %h", out_port, exp_out);
            end
`ifdef SWITCH_DEBOUNCE_EDGE_EN
            vectors++;
            if (rise_pulse[17] !== 1'b0) begin
                miscompares++; $display("FAIL glitch_pulse: rise17 %b want 0", rise_pulse[17]);
            end
`endif
        end
    endtask

    task automatic test_simultaneous();
        int n, chg; bit seen;
        in_port = 18'h2AAAA;
        n = 0; chg = 0; seen = 1'b0;
        while (n < 30) begin
            step(); n++;
            vectors++;
            if (out_port !== exp_out || (out_port !== 18'h00000 && out_port !== 18'h2AAAA)) begin
                miscompares++; $display("FAIL simul_track: got %h want %h", out_port, exp_out);
            end
            if (!seen && out_port === 18'h2AAAA) begin
                seen = 1'b1;
                vectors++;
                if (n < 11 || n > 14) begin
                    miscompares++; $display("FAIL simul_latency: got %0d clk want 11..14", n);
                end
            end
`ifdef SWITCH_DEBOUNCE_EDGE_EN
            if (changed === 1'b1) chg++;
`endif
        end
        vectors++;
        if (!seen) begin
            miscompares++; $display("FAIL simul_seen: got %h want %h", out_port, 18'h2AAAA);
        end
`ifdef SWITCH_DEBOUNCE_EDGE_EN
        vectors++;
        if (chg != 1) begin
            miscompares++; $display("FAIL simul_changed: got %0d pulses want 1", chg);
        end
`endif
    endtask

    task automatic test_midcount_reset();
        int n; bit seen;
        in_port = '0; idle(20);
        in_port[3] = 1'b1;
        n = 0;
        while (ticks_seen[3] < 2 && n < 20) begin
            step(); n++;
        end
        vectors++;
        if (ticks_seen[3] != 2 || out_port !== 18'h00000) begin
            miscompares++; $display("FAIL mid_precount: ticks %0d out %h want 2 / 0", ticks_seen[3], out_port);
        end
        reset_n = 1'b0; model_reset();
        step();
        reset_n = 1'b1;
        n = 0; seen = 1'b0;
        while (!seen && n < 30) begin
            step(); n++;
            vectors++;
            if (out_port !== exp_out) begin
                miscompares++; $display("FAIL mid_track: got %h want %h", out_port, exp_out);
            end
            if (out_port[3] === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen || n < 11 || n > 14) begin
            miscompares++; $display("FAIL mid_latency: got %0d clk (seen=%0d) want 11..14", n, seen);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                reset_n = 1'b0; model_reset();
                step();
                reset_n = 1'b1;
            end else if ($urandom_range(0, 7) == 0) begin
                in_port = in_port ^ W'($urandom & $urandom & $urandom);
            end
            step();
            vectors++;
            if (out_port !== exp_out) begin
                miscompares++; $display("FAIL random_out: cycle %0d got %h want %h", c, out_port, exp_out);
            end
`ifdef SWITCH_DEBOUNCE_EDGE_EN
            vectors++;
            if (rise_pulse !== exp_rise || fall_pulse !== exp_fall || changed !== exp_changed) begin
                miscompares++;
                $display("FAIL random_pulse: cycle %0d rise %h/%h fall %h/%h chg %b/%b", c,
                         rise_pulse, exp_rise, fall_pulse, exp_fall, changed, exp_changed);
            end
`endif
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_change();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_midcount_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
